// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the uart_tx_sched scheduler: state encoding,
// default line settings and the frame-timing derivations.
package uart_tx_sched_pkg;

    // Default line settings, shared with the uart_tx/uart_rx instances
    localparam int DEF_BAUD_RATE = 32'sd9600;
    localparam int DEF_CLK_FREQ  = 32'sd50_000_000;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    // Clock cycles per bit period (integer division, truncating)
    function automatic int calc_bit_cnt(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Clock cycles per frame: start + 8 data + stop, plus optional idle bits
    function automatic int calc_frame_cnt(input int clk_hz, input int baud, input int stop_gap);
        return calc_bit_cnt(clk_hz, baud) * (32'sd10 + stop_gap);
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter. With a single request that requester wins;
// with both, the one that did not win last time wins. Output is one-hot or zero.
module uart_tx_sched_rr_arb2
    import uart_tx_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic [1:0] gnt_raw_s;

    // Pick a winner from the request vector, then gate with enable
    always_comb begin
        gnt_raw_s = 2'b00;
        gnt_id    = 1'b0;
        case (req)
            2'b01: begin
                gnt_raw_s = 2'b01;
                gnt_id    = 1'b0;
            end
            2'b10: begin
                gnt_raw_s = 2'b10;
                gnt_id    = 1'b1;
            end
            2'b11: begin
                if (last_grant) begin
                    gnt_raw_s = 2'b01;
                    gnt_id    = 1'b0;
                end else begin
                    gnt_raw_s = 2'b10;
                    gnt_id    = 1'b1;
                end
            end
            default: begin
                gnt_raw_s = 2'b00;
                gnt_id    = 1'b0;
            end
        endcase
        if (en) begin
            gnt = gnt_raw_s;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler in front of uart_tx. Accepts one byte from one of
// two valid/ready requesters, pulses flag_begin with the byte on ser_to_para,
// then holds off for one frame time since uart_tx has no busy indication.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int UART_BAUD_RATE = DEF_BAUD_RATE,
    parameter int CLK_FREQ       = DEF_CLK_FREQ,
    parameter int STOP_GAP       = 32'sd0
)(
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic       tx_en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       flag_begin,
    output logic [7:0] ser_to_para,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    localparam int FRAME_CNT = calc_frame_cnt(CLK_FREQ, UART_BAUD_RATE, STOP_GAP);
    localparam int CNT_W     = $clog2(FRAME_CNT + 32'sd1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CNT - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sched_state_e     state_r;
    sched_state_e     state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             last_grant_r;
    logic             grant_id_r;
    logic [7:0]       ser_to_para_r;
    logic             flag_begin_r;
    logic             busy_r;
    logic             frame_done_r;

    logic [1:0]       gnt_s;
    logic             gnt_id_s;
    logic             arb_en_s;
    logic             accept_s;
    logic [7:0]       data_s;

    // Ready only while idle and enabled; the reset term keeps ready low during reset
    assign arb_en_s = tx_en & (state_r == ST_IDLE) & sys_rstn;

    uart_tx_sched_rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_r),
        .en         (arb_en_s),
        .gnt        (gnt_s),
        .gnt_id     (gnt_id_s)
    );

    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];
    assign accept_s   = gnt_s[0] | gnt_s[1];

    // Next-state and counter logic. The counter is loaded on accept and runs
    // through START and WAIT, so flag_begin plus the hold-off spans exactly
    // FRAME_CNT cycles and back-to-back starts are FRAME_CNT+1 cycles apart.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        data_s  = req0_data;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_START;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        if (gnt_s[1]) begin
            data_s = req1_data;
        end else begin
            data_s = req0_data;
        end
    end

    // FSM state and frame counter registers
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered outputs and arbitration history, all derived from the next state
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            flag_begin_r  <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            ser_to_para_r <= 8'hFF;
            grant_id_r    <= 1'b0;
            last_grant_r  <= 1'b1;
        end else begin
            flag_begin_r <= (state_s == ST_START);
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_s == ST_WAIT) && (cnt_s == CNT_ZERO);
            if (accept_s) begin
                ser_to_para_r <= data_s;
                grant_id_r    <= gnt_id_s;
                last_grant_r  <= gnt_id_s;
            end
        end
    end

    assign flag_begin  = flag_begin_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign ser_to_para = ser_to_para_r;
    assign grant_id    = grant_id_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a constant vector table for single
// accepts after reset, hand sequences for alternation, pause and mid-frame
// reset, and a randomized run against a frame-timeline reference model.
module tb_uart_tx_sched;

    localparam int TB_CLK  = 1600;
    localparam int TB_BAUD = 100;
    localparam int TB_GAP  = 2;
    localparam int FRAME   = (TB_CLK / TB_BAUD) * (10 + TB_GAP);

    logic       sys_clk    = 1'b0;
    logic       sys_rstn   = 1'b0;
    logic       tx_en      = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       req0_ready;
    logic       req1_ready;
    logic       flag_begin;
    logic [7:0] ser_to_para;
    logic       busy;
    logic       grant_id;
    logic       frame_done;

    uart_tx_sched #(
        .UART_BAUD_RATE (TB_BAUD),
        .CLK_FREQ       (TB_CLK),
        .STOP_GAP       (TB_GAP)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rstn    (sys_rstn),
        .tx_en       (tx_en),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .flag_begin  (flag_begin),
        .ser_to_para (ser_to_para),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_done  (frame_done)
    );

    // 10 ns clock
    always #5 sys_clk = ~sys_clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: the scheduler is free again at cycle free_at; a frame
    // accepted at cycle last_acc owns cycles last_acc+1 .. free_at-1.
    int         t;
    int         free_at;
    int         last_acc;
    logic       m_last;
    logic [7:0] m_data;
    logic       m_gid;
    bit         record;
    int         flag_t[$];
    logic [7:0] flag_d[$];

    typedef struct {
        logic       en;
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic [7:0] ser;
        logic       gid;
        logic       acc;
    } tv_t;

    tv_t tv [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        free_at  = t;
        last_acc = -1;
        m_last   = 1'b1;
        m_data   = 8'hFF;
        m_gid    = 1'b0;
    endtask

    // Called at the #1 point after a rising edge; leaves the bench at the same point
    task automatic do_reset();
        sys_rstn   = 1'b0;
        tx_en      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_ser",    32'(ser_to_para), 32'hFF);
        chk("rst_gid",    32'(grant_id),    32'd0);
        chk("rst_flag",   32'(flag_begin),  32'd0);
        chk("rst_done",   32'(frame_done),  32'd0);
        chk("rst_ready0", 32'(req0_ready),  32'd0);
        chk("rst_ready1", 32'(req1_ready),  32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rstn = 1'b1;
        t++;
        model_reset();
    endtask

    // One clock cycle checked against the reference model
    task automatic step(input logic en, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1);
        bit idle;
        int g;
        tx_en      = en;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        #4;
        idle = (t >= free_at);
        g = -1;
        if (idle && en) begin
            if (v0 && v1) g = m_last ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("flag_begin", 32'(flag_begin), 32'(last_acc >= 0 && t == last_acc + 1));
        chk("busy",       32'(busy),       32'(last_acc >= 0 && t > last_acc && t < free_at));
        chk("frame_done", 32'(frame_done), 32'(last_acc >= 0 && t == free_at - 1));
        chk("ser_to_para", 32'(ser_to_para), 32'(m_data));
        chk("grant_id",   32'(grant_id),   32'(m_gid));
        if (record && flag_begin === 1'b1) begin
            flag_t.push_back(t);
            flag_d.push_back(ser_to_para);
        end
        if (g >= 0) begin
            last_acc = t;
            free_at  = t + 1 + FRAME;
            m_last   = (g == 1);
            m_gid    = (g == 1);
            m_data   = (g == 1) ? d1 : d0;
        end
        t++;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        t      = 0;
        record = 1'b0;
        tv[0] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
        tv[1] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1};
        tv[2] = '{1'b1, 1'b1, 1'b1, 8'hA0, 8'hB1, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1};
        tv[3] = '{1'b0, 1'b1, 1'b1, 8'hA0, 8'hB1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        model_reset();
        @(posedge sys_clk);
        #1;

        // Vector table: one cycle of requests in the first IDLE cycle after reset
        for (int i = 0; i < 6; i++) begin
            do_reset();
            tx_en      = tv[i].en;
            req0_valid = tv[i].v0;
            req0_data  = tv[i].d0;
            req1_valid = tv[i].v1;
            req1_data  = tv[i].d1;
            #4;
            chk("tv_ready0", 32'(req0_ready), 32'(tv[i].r0));
            chk("tv_ready1", 32'(req1_ready), 32'(tv[i].r1));
            @(posedge sys_clk);
            #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk("tv_flag", 32'(flag_begin),  32'(tv[i].acc));
            chk("tv_busy", 32'(busy),        32'(tv[i].acc));
            chk("tv_ser",  32'(ser_to_para), 32'(tv[i].ser));
            chk("tv_gid",  32'(grant_id),    32'(tv[i].gid));
            @(posedge sys_clk);
            #1;
        end

        // Both requesters valid continuously: alternation and start spacing
        do_reset();
        flag_t.delete();
        flag_d.delete();
        record = 1'b1;
        for (int i = 0; i < 4 * (FRAME + 1) + 3; i++) step(1'b1, 1'b1, 8'hA0, 1'b1, 8'hB1);
        record = 1'b0;
        chk("alt_flag_count", 32'(flag_t.size() >= 4), 32'd1);
        for (int i = 0; i < flag_t.size() && i < 4; i++) begin
            chk("alt_data", 32'(flag_d[i]), (i % 2 == 1) ? 32'hB1 : 32'hA0);
            if (i > 0) chk("alt_spacing", 32'(flag_t[i] - flag_t[i-1]), 32'(FRAME + 1));
        end

        // Paused with a pending request, then enabled: accept in the same cycle
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A);
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h5A);
        // Pause during the frame: it still completes, nothing new is accepted
        for (int i = 0; i < FRAME + 20; i++) step(1'b0, 1'b1, 8'h6B, 1'b1, 8'h7C);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h6B, 1'b1, 8'h7C);

        // Reset mid-frame after a requester-0 grant; first contention after goes to req0
        do_reset();
        step(1'b1, 1'b1, 8'hC3, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        do_reset();
        step(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
        chk("post_rst_gid", 32'(grant_id), 32'd0);
        for (int i = 0; i < FRAME + 5; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        // Randomized traffic with pauses, dropped valids and occasional resets
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 7) != 0,
                     $urandom_range(0, 2) != 0, 8'($urandom),
                     $urandom_range(0, 2) != 0, 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
